// File: rtl/hvac_pkg.sv
// hvac_pkg: shared types and constants for the HVAC sequencer.
//   hvac_state_t : plant state, encoded to match the external mode code
//   RGB_*        : indicator codes driven on rgb_out
//   MODE_W       : width of the mode output
//   rgb_of()     : state to indicator decode
package hvac_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAT    = 2'd1,
    ST_COOL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } hvac_state_t;

  localparam logic [2:0] RGB_HEAT = 3'b100;
  localparam logic [2:0] RGB_COOL = 3'b001;
  localparam logic [2:0] RGB_IDLE = 3'b010;

  function automatic logic [2:0] rgb_of(input hvac_state_t s);
    case (s)
      ST_HEAT: rgb_of = RGB_HEAT;
      ST_COOL: rgb_of = RGB_COOL;
      default: rgb_of = RGB_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hvac_timer.sv
// hvac_timer: saturating cycle counter with synchronous clear and a
// terminal-count compare.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : zero the count on this edge
//   limit        : terminal count
//   done         : count has reached (or passed) limit
// The count starts from zero after every clear and steps by one, so the
// >= compare first becomes true exactly when count == limit.
module hvac_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign done = (cnt >= limit);

endmodule

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heating/cooling plant sequencer with hysteresis,
// minimum-run and lockout timing, and a single authoritative mode that
// drives the relays and the RGB indicator.
//   clk, reset_n          : clock, asynchronous active-low reset
//   enable                : plant allowed to run
//   temp_set/desired_temp : setpoint strobe and value
//   temp_in               : measured temperature
//   heat_on/cool_on/fan_on: relay outputs (registered)
//   rgb_out               : 100 heat, 001 cool, 010 idle/lockout
//   mode                  : current state code
// Optional: define HVAC_FAN_OVERRUN_EN to hold the fan on for FAN_OVERRUN
// cycles after the plant stops.
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int TEMP_W      = 8,
  parameter int HYST        = 1,
  parameter int MIN_RUN     = 16,
  parameter int MIN_OFF     = 16,
  parameter int FAN_OVERRUN = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              temp_set,
  input  logic [TEMP_W-1:0] desired_temp,
  input  logic [TEMP_W-1:0] temp_in,
  output logic              heat_on,
  output logic              cool_on,
  output logic              fan_on,
  output logic [2:0]        rgb_out,
  output logic [MODE_W-1:0] mode
);

  localparam int RO_MAX  = (MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF;
  localparam int CNT_MAX = (FAN_OVERRUN > RO_MAX) ? FAN_OVERRUN : RO_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(MIN_OFF - 1);
  localparam logic [TEMP_W:0]  HYST_X  = (TEMP_W+1)'(HYST);

  hvac_state_t       state, state_nx;
  logic [TEMP_W-1:0] setpoint;
  logic              sp_valid;
  logic              cnt_done;
  logic              want_heat, want_cool;
  logic [TEMP_W:0]   sp_x, t_x;

  // One extra bit so setpoint+HYST and temp_in+HYST never wrap.
  assign sp_x      = {1'b0, setpoint};
  assign t_x       = {1'b0, temp_in};
  assign want_heat = sp_valid && enable && ((t_x + HYST_X) < sp_x);
  assign want_cool = sp_valid && enable && (t_x > (sp_x + HYST_X));

  // Residency counter; cleared on every state change so it counts cycles
  // spent in the current state.
  hvac_timer #(.W(CNT_W)) u_state_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_nx != state),
    .limit   ((state == ST_LOCKOUT) ? OFF_LIM : RUN_LIM),
    .done    (cnt_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (want_heat)      state_nx = ST_HEAT;
        else if (want_cool) state_nx = ST_COOL;
      end
      ST_HEAT: begin
        // Disable bypasses minimum run; reversal always goes via lockout.
        if (!enable)                              state_nx = ST_LOCKOUT;
        else if ((temp_in >= setpoint) && cnt_done) state_nx = ST_LOCKOUT;
      end
      ST_COOL: begin
        if (!enable)                              state_nx = ST_LOCKOUT;
        else if ((temp_in <= setpoint) && cnt_done) state_nx = ST_LOCKOUT;
      end
      ST_LOCKOUT: if (cnt_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef HVAC_FAN_OVERRUN_EN
  localparam logic [CNT_W-1:0] FAN_LIM = CNT_W'(FAN_OVERRUN - 1);
  logic plant_cur, plant_nx, fan_done;
  assign plant_cur = (state == ST_HEAT) || (state == ST_COOL);
  assign plant_nx  = (state_nx == ST_HEAT) || (state_nx == ST_COOL);

  // Held at zero while the plant runs; counts the overrun once it stops.
  hvac_timer #(.W(CNT_W)) u_fan_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (plant_cur),
    .limit   (FAN_LIM),
    .done    (fan_done)
  );
`endif

  // Outputs are registered from the next state so they always equal a
  // decode of the state register without any combinational relay path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      setpoint <= '0;
      sp_valid <= 1'b0;
      heat_on  <= 1'b0;
      cool_on  <= 1'b0;
      fan_on   <= 1'b0;
      rgb_out  <= RGB_IDLE;
      mode     <= ST_IDLE;
    end else begin
      state <= state_nx;
      if (temp_set) begin
        setpoint <= desired_temp;
        sp_valid <= 1'b1;
      end
      heat_on <= (state_nx == ST_HEAT);
      cool_on <= (state_nx == ST_COOL);
`ifdef HVAC_FAN_OVERRUN_EN
      // Stay on through the exit edge, then until the overrun expires.
      fan_on  <= plant_nx | (fan_on & (plant_cur | !fan_done));
`else
      fan_on  <= (state_nx == ST_HEAT) || (state_nx == ST_COOL);
`endif
      rgb_out <= rgb_of(state_nx);
      mode    <= state_nx;
    end
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
module tb_hvac_sequencer;
  localparam int TEMP_W = 8;

`ifdef HVAC_FAN_OVERRUN_EN
  localparam bit FAN_EN = 1'b1;
`else
  localparam bit FAN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              temp_set;
  logic [TEMP_W-1:0] desired_temp;
  logic [TEMP_W-1:0] temp_in;
  logic              heat_on, cool_on, fan_on;
  logic [2:0]        rgb_out;
  logic [1:0]        mode;

  int n_cmp = 0;
  int n_err = 0;

  hvac_sequencer #(
    .TEMP_W(TEMP_W), .HYST(1), .MIN_RUN(4), .MIN_OFF(3), .FAN_OVERRUN(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .temp_set(temp_set),
    .desired_temp(desired_temp), .temp_in(temp_in),
    .heat_on(heat_on), .cool_on(cool_on), .fan_on(fan_on),
    .rgb_out(rgb_out), .mode(mode)
  );

  always #5 clk = ~clk;

  // Observed vector: {heat, cool, fan, rgb[2:0], mode[1:0]}
  task automatic chk(input string tag, input logic h, input logic c,
                     input logic f, input logic [2:0] rgb, input logic [1:0] md);
    logic [7:0] exp_v, obs_v;
    exp_v = {h, c, f, rgb, md};
    obs_v = {heat_on, cool_on, fan_on, rgb_out, mode};
    n_cmp++;
    assert (obs_v === exp_v)
      else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b (heat cool fan rgb mode)", tag, obs_v, exp_v);
      end
  endtask

  task automatic chk_idle(input string tag, input logic f);
    chk(tag, 1'b0, 1'b0, f, 3'b010, 2'd0);
  endtask
  task automatic chk_heat(input string tag);
    chk(tag, 1'b1, 1'b0, 1'b1, 3'b100, 2'd1);
  endtask
  task automatic chk_cool(input string tag);
    chk(tag, 1'b0, 1'b1, 1'b1, 3'b001, 2'd2);
  endtask
  task automatic chk_lock(input string tag, input logic f);
    chk(tag, 1'b0, 1'b0, f, 3'b010, 2'd3);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called just after the edge that left HEAT/COOL: 3 lockout cycles, then
  // idle; with the overrun build the fan stays on for the first 5 cycles.
  task automatic chk_post(input string tag);
    for (int k = 0; k < 6; k++) begin
      logic f;
      f = FAN_EN && (k < 5);
      if (k < 3) chk_lock($sformatf("%s lockout k%0d", tag, k), f);
      else       chk_idle($sformatf("%s idle k%0d", tag, k), f);
      tick();
    end
  endtask

  initial begin
    // 1: reset, then idle with no setpoint
    reset_n = 1'b0; enable = 1'b1; temp_set = 1'b0;
    desired_temp = '0; temp_in = 8'd50;
    tick();
    chk_idle("reset values", 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("t1 idle no setpoint c%0d", i), 1'b0);
    end

    // 2: setpoint 72, temp 68 -> heat at N+1, 4 heat cycles, 3 lockout
    temp_set = 1'b1; desired_temp = 8'd72; temp_in = 8'd68;
    tick();
    chk_idle("t2 edge N still idle", 1'b0);
    temp_set = 1'b0;
    tick();
    chk_heat("t2 heat c1");
    temp_in = 8'd72;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_heat($sformatf("t2 heat c%0d", i));
    end
    tick();
    chk_post("t2");

    // 3: hysteresis band around 72
    temp_in = 8'd73;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("t3 temp73 idle c%0d", i), 1'b0);
    end
    temp_in = 8'd71;
    tick();
    chk_idle("t3 temp71 idle", 1'b0);
    temp_in = 8'd74;
    tick();
    chk_cool("t3 cool c1");
    temp_in = 8'd72;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_cool($sformatf("t3 cool c%0d", i));
    end
    tick();
    chk_post("t3");

    // 4: disable in heat's second cycle -> immediate lockout
    temp_in = 8'd68;
    tick();
    chk_heat("t4 heat c1");
    tick();
    chk_heat("t4 heat c2");
    enable = 1'b0;
    tick();
    chk_post("t4");

    // 5: async reset mid-cool, then idle until a new setpoint
    temp_in = 8'd74; enable = 1'b1;
    tick();
    chk_cool("t5 cool c1");
    tick();
    chk_cool("t5 cool c2");
    #2 reset_n = 1'b0;
    #1 chk_idle("t5 async reset outputs", 1'b0);
    tick();
    chk_idle("t5 held in reset", 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("t5 idle after reset c%0d", i), 1'b0);
    end

    // New setpoint after reset: 60 with temp 74 -> cool at N+1
    temp_set = 1'b1; desired_temp = 8'd60;
    tick();
    chk_idle("t5 new setpoint edge N", 1'b0);
    temp_set = 1'b0;
    tick();
    chk_cool("t5 cool after new setpoint");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
